// File: rtl/jam_cost_responder.sv
// Worker/job cost responder: an 8x8 table of 7-bit costs, filled by a row-major
// valid/ready load stream and read combinationally by the assignment initiator.
module jam_cost_responder #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             LD_START,
    input  logic             LD_VALID,
    output logic             LD_READY,
    input  logic [6:0]       LD_DATA,
    input  logic             LD_LAST,
    input  logic [2:0]       W,
    input  logic [2:0]       J,
    output logic [6:0]       Cost,
    output logic             TBL_READY,
    output logic             LD_ERR,
    output logic [CNT_W-1:0] RD_COUNT,
    output logic [1:0]       fsm_state
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] READY = 2'd2;

    // Load handshake: a beat is transferred on a rising edge where LD_VALID and
    // LD_READY are both high; LD_READY depends only on state, never on LD_VALID.
    logic [1:0]       state;
    logic [5:0]       ptr;
    logic             ld_err;
    logic [CNT_W-1:0] rd_count;
    logic [5:0]       prev_addr;
    logic [6:0]       mem [64];

    logic       xfer;
    logic       wr_en;
    logic [5:0] addr;

    assign addr      = {W, J};
    assign xfer      = (state == LOAD) && LD_VALID;
    // A restart in the same cycle as a beat drops that beat.
    assign wr_en     = xfer && !LD_START;

    assign LD_READY  = (state == LOAD);
    assign TBL_READY = (state == READY);
    assign LD_ERR    = ld_err;
    assign RD_COUNT  = rd_count;
    assign fsm_state = state;

    // Zero-latency lookup: the initiator samples Cost one edge after changing W/J.
    assign Cost = TBL_READY ? mem[addr] : 7'd0;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[ptr] <= LD_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= EMPTY;
            ptr       <= 6'd0;
            ld_err    <= 1'b0;
            rd_count  <= '0;
            prev_addr <= 6'd0;
        end else begin
            prev_addr <= addr;
            if (LD_START) begin
                state    <= LOAD;
                ptr      <= 6'd0;
                ld_err   <= 1'b0;
                rd_count <= '0;
            end else begin
                case (state)
                    LOAD: begin
                        if (xfer) begin
                            if (LD_LAST && (ptr == 6'd63)) begin
                                state <= READY;
                                ptr   <= 6'd0;
                            end else if (LD_LAST || (ptr == 6'd63)) begin
                                // Early end or overrun: data stays, table is not usable.
                                state  <= EMPTY;
                                ld_err <= 1'b1;
                                ptr    <= 6'd0;
                            end else begin
                                ptr <= ptr + 6'd1;
                            end
                        end
                    end
                    READY: begin
                        if ((addr != prev_addr) && (rd_count != {CNT_W{1'b1}})) begin
                            rd_count <= rd_count + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= EMPTY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jam_cost_responder.sv
// Bench for jam_cost_responder: randomized loads and lookups against a
// table-image model, plus literal checks of the worked examples.
module tb_jam_cost_responder;

    logic        CLK;
    logic        RST_N;
    logic        LD_START;
    logic        LD_VALID;
    logic [6:0]  LD_DATA;
    logic        LD_LAST;
    logic [2:0]  W;
    logic [2:0]  J;
    logic        ld_ready;
    logic [6:0]  cost;
    logic        tbl_ready;
    logic        ld_err;
    logic [15:0] rd_count;
    logic [1:0]  fsm_state;
    logic        ld_ready4;
    logic [6:0]  cost4;
    logic        tbl_ready4;
    logic        ld_err4;
    logic [3:0]  rd_count4;
    logic [1:0]  fsm_state4;

    jam_cost_responder #(.CNT_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .LD_START(LD_START), .LD_VALID(LD_VALID),
        .LD_READY(ld_ready), .LD_DATA(LD_DATA), .LD_LAST(LD_LAST), .W(W), .J(J),
        .Cost(cost), .TBL_READY(tbl_ready), .LD_ERR(ld_err), .RD_COUNT(rd_count),
        .fsm_state(fsm_state)
    );

    jam_cost_responder #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST_N(RST_N), .LD_START(LD_START), .LD_VALID(LD_VALID),
        .LD_READY(ld_ready4), .LD_DATA(LD_DATA), .LD_LAST(LD_LAST), .W(W), .J(J),
        .Cost(cost4), .TBL_READY(tbl_ready4), .LD_ERR(ld_err4), .RD_COUNT(rd_count4),
        .fsm_state(fsm_state4)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- check bookkeeping ----------------
    int n_pass  = 0;
    int n_total = 0;
    bit check_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle/no table, 1 accepting load beats, 2 table usable
    int m_mode = 0;
    int m_beats = 0;
    int m_tbl [64];
    int m_err = 0;
    int m_rd16 = 0;
    int m_rd4 = 0;
    int m_prev = 0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_mode = 0; m_beats = 0; m_err = 0; m_rd16 = 0; m_rd4 = 0; m_prev = 0;
        end else begin
            int a;
            a = W * 8 + J;
            if (LD_START) begin
                m_mode = 1; m_beats = 0; m_err = 0; m_rd16 = 0; m_rd4 = 0;
            end else if (m_mode == 1 && LD_VALID) begin
                m_tbl[m_beats] = LD_DATA;
                if (LD_LAST && m_beats == 63) begin
                    m_mode = 2; m_beats = 0;
                end else if (LD_LAST || m_beats == 63) begin
                    m_mode = 0; m_err = 1; m_beats = 0;
                end else begin
                    m_beats++;
                end
            end else if (m_mode == 2 && a != m_prev) begin
                if (m_rd16 < 65535) m_rd16++;
                if (m_rd4 < 15) m_rd4++;
            end
            m_prev = a;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge CLK) begin
        if (check_en && RST_N) begin
            int a;
            a = W * 8 + J;
            chk("ld_ready", ld_ready, (m_mode == 1) ? 1 : 0);
            chk("tbl_ready", tbl_ready, (m_mode == 2) ? 1 : 0);
            chk("ld_err", ld_err, m_err);
            chk("cost", cost, (m_mode == 2) ? m_tbl[a] : 0);
            chk("rd_count", rd_count, m_rd16);
            chk("rd_count4", rd_count4, m_rd4);
        end
    end

    // ---------------- driver tasks ----------------
    logic [6:0] img [64];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_addr(input int a);
        W = 3'(a / 8);
        J = 3'(a % 8);
    endtask

    task automatic start_load();
        LD_START = 1'b1;
        tick();
        LD_START = 1'b0;
    endtask

    task automatic send_beats(input int n, input int last_idx, input int gap_pct, input bit rand_addr);
        int beat = 0;
        int budget = 0;
        while (beat < n && budget < 2000) begin
            LD_VALID = ($urandom_range(99) >= gap_pct);
            LD_DATA  = LD_VALID ? img[beat] : 7'($urandom);
            LD_LAST  = LD_VALID && (beat == last_idx);
            if (rand_addr) begin
                W = 3'($urandom);
                J = 3'($urandom);
            end
            tick();
            if (LD_VALID) beat++;
            budget++;
        end
        if (beat < n) chk("load_budget", beat, n);
        LD_VALID = 1'b0;
        LD_LAST  = 1'b0;
    endtask

    task automatic scan_table();
        for (int i = 0; i < 64; i++) begin
            set_addr(i);
            #1;
            chk("scan_cost", cost, img[i]);
            tick();
        end
    endtask

    // ---------------- main sequence ----------------
    int seq [8] = '{29, 63, 1, 2, 3, 4, 5, 6};

    initial begin
        RST_N = 1'b1; LD_START = 1'b0; LD_VALID = 1'b0; LD_DATA = 7'd0; LD_LAST = 1'b0;
        W = 3'd0; J = 3'd0;
        #2 RST_N = 1'b0;
        #20;
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_tbl_ready", tbl_ready, 0);
        chk("rst_ld_err", ld_err, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_cost", cost, 0);
        tick();
        RST_N = 1'b1;
        check_en = 1;

        // lookup before any load
        W = 3'd2; J = 3'd4;
        repeat (3) tick();
        chk("preload_cost", cost, 0);
        chk("preload_tbl_ready", tbl_ready, 0);
        chk("preload_rd_count", rd_count, 0);

        // full back-to-back load, address held at 0
        W = 3'd0; J = 3'd0;
        for (int i = 0; i < 64; i++) img[i] = 7'(i % 100);
        start_load();
        send_beats(64, 63, 0, 0);
        chk("full_tbl_ready", tbl_ready, 1);
        chk("full_ld_err", ld_err, 0);

        // eight distinct lookups then hold
        for (int k = 0; k < 8; k++) begin
            set_addr(seq[k]);
            #1;
            if (k == 0) chk("cost_w3_j5", cost, 29);
            if (k == 1) chk("cost_w7_j7", cost, 63);
            tick();
        end
        repeat (5) tick();
        chk("rd_count_8", rd_count, 8);
        chk("rd_count4_8", rd_count4, 8);
        for (int k = 0; k < 20; k++) begin
            set_addr((k % 2 == 0) ? 10 : 11);
            tick();
        end
        chk("rd_count4_sat", rd_count4, 15);
        chk("rd_count_28", rd_count, 28);

        // early end on the 10th beat
        start_load();
        send_beats(10, 9, 0, 1);
        chk("early_ld_err", ld_err, 1);
        chk("early_tbl_ready", tbl_ready, 0);
        chk("early_ld_ready", ld_ready, 0);
        start_load();
        chk("restart_clears_err", ld_err, 0);
        // overrun: 64 beats without LD_LAST
        send_beats(64, -1, 0, 1);
        chk("overrun_ld_err", ld_err, 1);
        chk("overrun_tbl_ready", tbl_ready, 0);

        // backpressure with random gaps
        for (int i = 0; i < 64; i++) img[i] = 7'($urandom);
        start_load();
        send_beats(64, 63, 40, 1);
        chk("bp_tbl_ready", tbl_ready, 1);
        scan_table();

        // restart colliding with a beat at ptr 30, then reload with new data
        for (int i = 0; i < 64; i++) img[i] = 7'($urandom);
        start_load();
        send_beats(30, -1, 30, 1);
        LD_START = 1'b1; LD_VALID = 1'b1; LD_DATA = ~img[30];
        tick();
        LD_START = 1'b0; LD_VALID = 1'b0;
        chk("collide_ld_ready", ld_ready, 1);
        for (int i = 0; i < 64; i++) img[i] = 7'($urandom);
        send_beats(64, 63, 20, 1);
        chk("reload_tbl_ready", tbl_ready, 1);
        scan_table();

        // asynchronous reset between edges
        set_addr(29);
        @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        chk("async_tbl_ready", tbl_ready, 0);
        chk("async_cost", cost, 0);
        chk("async_rd_count", rd_count, 0);
        #10 RST_N = 1'b1;
        repeat (3) tick();

        check_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
